// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_arbiter
// Function : Round-robin sharing of one SPI master among NREQ requesters,
//            with per-transaction timeout and one-hot acknowledge.
// Revision : 1.0
// ============================================================================
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_tx,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_rx,
  output logic              rsp_err,
  output logic [7:0]        m_reg,
  output logic              get_data,
  input  logic              spi_done,
  input  logic [7:0]        spi_rx,
  output logic [NREQ-1:0]   slave_sel,
  output logic              busy
);

  localparam int c_iw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_iw-1:0] c_last_init = c_iw'(NREQ - 1);
  localparam logic [c_tw-1:0] c_tmax      = c_tw'(TIMEOUT - 1);
  localparam logic [c_tw-1:0] c_tone      = c_tw'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_iw-1:0] r_grant;
  logic [c_iw-1:0] r_last_grant;
  logic [c_tw-1:0] r_timer;

  logic [c_iw-1:0] w_winner;
  logic [c_iw-1:0] w_cand;
  logic            w_found;
  logic [7:0]      w_tx;
  logic [NREQ-1:0] w_onehot;

  // Search starts just above the previous winner so every requester gets a turn.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = c_iw'((int'(r_last_grant) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_tx     = '0;
    w_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_winner == c_iw'(k)) begin
        w_tx        = req_tx[8*k +: 8];
        w_onehot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= c_last_init;
      r_timer      <= '0;
      m_reg        <= '0;
      get_data     <= 1'b0;
      ack          <= '0;
      rsp_rx       <= '0;
      rsp_err      <= 1'b0;
      slave_sel    <= '0;
      busy         <= 1'b0;
    end else begin
      get_data <= 1'b0;
      ack      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant   <= w_winner;
            m_reg     <= w_tx;
            slave_sel <= w_onehot;
            busy      <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          get_data <= 1'b1;
          r_state  <= S_START;
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (spi_done) begin
            rsp_rx  <= spi_rx;
            rsp_err <= 1'b0;
            ack     <= slave_sel;
            r_state <= S_GAP;
          end else if (r_timer == c_tmax) begin
            rsp_rx  <= 8'h00;
            rsp_err <= 1'b1;
            ack     <= slave_sel;
            r_state <= S_GAP;
          end else begin
            r_timer <= r_timer + c_tone;
          end
        end
        S_GAP: begin
          slave_sel    <= '0;
          busy         <= 1'b0;
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_arbiter
// Function : Self-checking bench for spi_txn_arbiter (default and TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_spi_txn_arbiter;

  logic        global_clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_tx;
  logic        spi_done;
  logic [7:0]  spi_rx;
  bit          use16;

  logic [3:0] ack_a, ack_b, ack_m;
  logic [7:0] rsp_rx_a, rsp_rx_b, rsp_rx_m;
  logic       rsp_err_a, rsp_err_b, rsp_err_m;
  logic [7:0] m_reg_a, m_reg_b, m_reg_m;
  logic       get_data_a, get_data_b, get_data_m;
  logic [3:0] slave_sel_a, slave_sel_b, slave_sel_m;
  logic       busy_a, busy_b, busy_m;

  spi_txn_arbiter #(.NREQ(4), .TIMEOUT(255)) u_dut (
    .global_clk(global_clk), .reset(reset), .req(req), .req_tx(req_tx),
    .ack(ack_a), .rsp_rx(rsp_rx_a), .rsp_err(rsp_err_a), .m_reg(m_reg_a),
    .get_data(get_data_a), .spi_done(spi_done), .spi_rx(spi_rx),
    .slave_sel(slave_sel_a), .busy(busy_a)
  );

  spi_txn_arbiter #(.NREQ(4), .TIMEOUT(16)) u_dut16 (
    .global_clk(global_clk), .reset(reset), .req(req), .req_tx(req_tx),
    .ack(ack_b), .rsp_rx(rsp_rx_b), .rsp_err(rsp_err_b), .m_reg(m_reg_b),
    .get_data(get_data_b), .spi_done(spi_done), .spi_rx(spi_rx),
    .slave_sel(slave_sel_b), .busy(busy_b)
  );

  assign ack_m       = use16 ? ack_b       : ack_a;
  assign rsp_rx_m    = use16 ? rsp_rx_b    : rsp_rx_a;
  assign rsp_err_m   = use16 ? rsp_err_b   : rsp_err_a;
  assign m_reg_m     = use16 ? m_reg_b     : m_reg_a;
  assign get_data_m  = use16 ? get_data_b  : get_data_a;
  assign slave_sel_m = use16 ? slave_sel_b : slave_sel_a;
  assign busy_m      = use16 ? busy_b      : busy_a;

  initial global_clk = 1'b0;
  always #5 global_clk = ~global_clk;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] rx;
    logic       err;
  } exp_t;

  typedef struct {
    bit          rst;
    bit          use16;
    logic [3:0]  rq;
    logic [31:0] tx;
    int          g;
    logic [7:0]  m;
    int          dly;   // 0 = master never answers
    logic [7:0]  rx;
    bit          chg;
  } vec_t;

  exp_t sb[$];
  exp_t e_pop;
  vec_t vecs[10];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge global_clk) begin
    if (ack_m !== 4'b0000) begin
      chk("ack_onehot", $countones(ack_m), 1);
      if (sb.size() == 0) begin
        chk("unexpected_ack", {28'd0, ack_m}, 32'd0);
      end else begin
        e_pop = sb.pop_front();
        chk("ack_vec", {28'd0, ack_m}, {28'd0, e_pop.ack});
        chk("rsp_rx", {24'd0, rsp_rx_m}, {24'd0, e_pop.rx});
        chk("rsp_err", {31'd0, rsp_err_m}, {31'd0, e_pop.err});
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return {5'd0, ack_m, rsp_rx_m, rsp_err_m, m_reg_m, get_data_m, slave_sel_m, busy_m};
  endfunction

  task automatic do_reset();
    @(negedge global_clk);
    reset = 1'b0; req = '0; spi_done = 1'b0;
    repeat (2) @(negedge global_clk);
    reset = 1'b1;
    @(negedge global_clk);
    chk("reset_state", all_outs(), 32'd0);
  endtask

  // Called on a negedge while the selected DUT is idle.
  task automatic run_txn(input vec_t v);
    logic [3:0] oh;
    exp_t       e;
    int         n;
    int         n_exp;
    oh = 4'b0001 << v.g;
    req = v.rq;
    req_tx = v.tx;
    e.ack = oh;
    e.rx  = (v.dly == 0) ? 8'h00 : v.rx;
    e.err = (v.dly == 0);
    sb.push_back(e);
    @(negedge global_clk);
    chk("grant_sel", {28'd0, slave_sel_m}, {28'd0, oh});
    chk("grant_mreg", {24'd0, m_reg_m}, {24'd0, v.m});
    chk("grant_busy", {31'd0, busy_m}, 32'd1);
    @(negedge global_clk);
    chk("get_data", {31'd0, get_data_m}, 32'd1);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge global_clk);
      spi_done = 1'b0;
      if (i == 1) chk("get_data_pulse", {31'd0, get_data_m}, 32'd0);
      if (i == 2 && v.chg) req_tx = req_tx ^ 32'hFFFF_FFFF;
      if (ack_m !== 4'b0000) begin
        n = i;
        break;
      end
      if (i == v.dly) begin
        spi_done = 1'b1;
        spi_rx   = v.rx;
      end
    end
    n_exp = (v.dly == 0) ? 17 : v.dly + 1;
    chk("ack_latency", n, n_exp);
    chk("mreg_hold", {24'd0, m_reg_m}, {24'd0, v.m});
    req = '0;
    @(negedge global_clk);
    chk("idle_after", {23'd0, busy_m, slave_sel_m, ack_m}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t hv;
    reset = 1'b0; req = '0; req_tx = '0; spi_done = 1'b0; spi_rx = '0; use16 = 1'b0;

    vecs[0] = '{rst:1, use16:0, rq:4'b0001, tx:32'h000000FF, g:0, m:8'hFF, dly:20, rx:8'hAA, chg:0};
    vecs[1] = '{rst:1, use16:0, rq:4'b1111, tx:32'h44332211, g:0, m:8'h11, dly:3,  rx:8'h5A, chg:0};
    vecs[2] = '{rst:0, use16:0, rq:4'b1111, tx:32'h44332211, g:1, m:8'h22, dly:4,  rx:8'h5B, chg:0};
    vecs[3] = '{rst:0, use16:0, rq:4'b1111, tx:32'h44332211, g:2, m:8'h33, dly:5,  rx:8'h5C, chg:0};
    vecs[4] = '{rst:0, use16:0, rq:4'b1111, tx:32'h44332211, g:3, m:8'h44, dly:6,  rx:8'h5D, chg:0};
    vecs[5] = '{rst:0, use16:0, rq:4'b1111, tx:32'h44332211, g:0, m:8'h11, dly:7,  rx:8'h5E, chg:0};
    vecs[6] = '{rst:1, use16:1, rq:4'b0001, tx:32'h000000C3, g:0, m:8'hC3, dly:0,  rx:8'hEE, chg:0};
    vecs[7] = '{rst:0, use16:1, rq:4'b0010, tx:32'h00007E00, g:1, m:8'h7E, dly:5,  rx:8'h99, chg:0};
    vecs[8] = '{rst:0, use16:1, rq:4'b0100, tx:32'h00BD0000, g:2, m:8'hBD, dly:16, rx:8'h3C, chg:0};
    vecs[9] = '{rst:1, use16:0, rq:4'b0010, tx:32'h00005500, g:1, m:8'h55, dly:6,  rx:8'h77, chg:1};

    for (int i = 0; i < 10; i++) begin
      use16 = vecs[i].use16;
      if (vecs[i].rst) begin
        do_reset();
        spi_done = 1'b1;
        spi_rx   = 8'hDD;
        @(negedge global_clk);
        spi_done = 1'b0;
        chk("idle_spurious_done", {26'd0, busy_m, get_data_m, slave_sel_m}, 32'd0);
      end
      run_txn(vecs[i]);
    end

    // Abort a transaction in WAIT with an asynchronous reset.
    use16 = 1'b0;
    req = 4'b0100;
    req_tx = 32'h00AB00CD;
    repeat (5) @(negedge global_clk);
    chk("abort_in_wait", {31'd0, busy_m}, 32'd1);
    req = '0;
    #2 reset = 1'b0;
    #1 chk("async_reset_outs", all_outs(), 32'd0);
    repeat (2) @(negedge global_clk);
    reset = 1'b1;
    @(negedge global_clk);
    chk("post_reset_outs", all_outs(), 32'd0);
    hv = '{rst:0, use16:0, rq:4'b0101, tx:32'h00AB00CD, g:0, m:8'hCD, dly:4, rx:8'h12, chg:0};
    run_txn(hv);
    hv = '{rst:0, use16:0, rq:4'b0101, tx:32'h00AB00CD, g:2, m:8'hAB, dly:5, rx:8'h34, chg:0};
    run_txn(hv);

    repeat (3) @(negedge global_clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
